// File: rtl/bg_rom_sched.sv
// Single-port background ROM sequencer: the raster display path always owns the port
// when it issues; one secondary pixel query borrows the port on idle cycles.
module bg_rom_sched #(
    parameter int                 IMG_W    = 352,
    parameter int                 IMG_H    = 176,
    parameter int                 ADDR_W   = 16,
    parameter int                 COLOR_W  = 12,
    parameter int                 WIN_X0   = 144,
    parameter int                 WIN_Y0   = 152,
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'h808
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic               de,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    input  logic               q_req,
    input  logic [8:0]         q_x,
    input  logic [7:0]         q_y,
    output logic               q_ack,
    output logic [COLOR_W-1:0] q_color,
    output logic               q_oob,
    output logic               q_busy
);

    localparam logic [9:0]  X_LO    = 10'(WIN_X0);
    localparam logic [9:0]  X_HI    = 10'(WIN_X0 + IMG_W - 1);
    localparam logic [9:0]  Y_LO    = 10'(WIN_Y0);
    localparam logic [9:0]  Y_HI    = 10'(WIN_Y0 + IMG_H - 1);
    localparam logic [31:0] IMG_W_U = 32'(IMG_W);
    localparam logic [31:0] IMG_H_U = 32'(IMG_H);

    typedef enum logic [1:0] {IDLE, WAIT, CAP, DONE} q_state_t;

    q_state_t           state_q;
    logic [8:0]         qx_q;
    logic [7:0]         qy_q;
    logic               q_ack_q, q_oob_q, q_busy_q;
    logic [COLOR_W-1:0] q_color_q;

    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
    logic               vld_p1_d, vld_p1_q;
    logic               in_p1_d, in_p1_q;
    logic [COLOR_W-1:0] pix_color_d, pix_color_q;
    logic               pix_valid_d, pix_valid_q;

    logic               inwin, disp_issue, q_is_oob;
    logic [9:0]         dx, dy;
    logic [ADDR_W-1:0]  disp_addr, qry_addr;

    // Unsigned window compare: the subtractions below are only used when inwin holds.
    always_comb begin
        inwin      = (draw_x >= X_LO) && (draw_x <= X_HI) &&
                     (draw_y >= Y_LO) && (draw_y <= Y_HI);
        disp_issue = pix_en & de & inwin;
        dx         = draw_x - X_LO;
        dy         = draw_y - Y_LO;
        disp_addr  = ADDR_W'(dy) * ADDR_W'(IMG_W) + ADDR_W'(dx);
        qry_addr   = ADDR_W'(qy_q) * ADDR_W'(IMG_W) + ADDR_W'(qx_q);
        q_is_oob   = (32'(q_x) >= IMG_W_U) || (32'(q_y) >= IMG_H_U);
    end

    // Stage p1: address issue (display wins the port); stage p2: colour capture.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (disp_issue)
            rom_addr_d = disp_addr;
        else if (state_q == WAIT)
            rom_addr_d = qry_addr;
        vld_p1_d    = pix_en & de;
        in_p1_d     = inwin;
        pix_valid_d = vld_p1_q;
        pix_color_d = pix_color_q;
        if (vld_p1_q)
            pix_color_d = in_p1_q ? rom_color : BG_COLOR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            vld_p1_q    <= 1'b0;
            in_p1_q     <= 1'b0;
            pix_color_q <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            vld_p1_q    <= vld_p1_d;
            in_p1_q     <= in_p1_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // CAP samples rom_color before any display issue on the same edge can move rom_addr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qx_q      <= '0;
            qy_q      <= '0;
            q_ack_q   <= 1'b0;
            q_oob_q   <= 1'b0;
            q_busy_q  <= 1'b0;
            q_color_q <= '0;
        end else begin
            q_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (q_req) begin
                        qx_q     <= q_x;
                        qy_q     <= q_y;
                        q_busy_q <= 1'b1;
                        if (q_is_oob) begin
                            state_q   <= DONE;
                            q_oob_q   <= 1'b1;
                            q_color_q <= BG_COLOR;
                            q_ack_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            q_oob_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!disp_issue)
                        state_q <= CAP;
                end
                CAP: begin
                    q_color_q <= rom_color;
                    q_ack_q   <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    q_busy_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_color = pix_color_q;
    assign pix_valid = pix_valid_q;
    assign q_ack     = q_ack_q;
    assign q_color   = q_color_q;
    assign q_oob     = q_oob_q;
    assign q_busy    = q_busy_q;

endmodule

// File: tb/tb_bg_rom_sched.sv
// Bench for bg_rom_sched: behavioural ROM, pixel and query scoreboards, scenario tasks.
module tb_bg_rom_sched;

    localparam logic [11:0] BG = 12'h808;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en, de;
    logic [9:0]  draw_x, draw_y;
    logic [15:0] rom_addr;
    logic [11:0] rom_color, pix_color;
    logic        pix_valid;
    logic        q_req;
    logic [8:0]  q_x;
    logic [7:0]  q_y;
    logic        q_ack;
    logic [11:0] q_color;
    logic        q_oob, q_busy;

    int total = 0;
    int bad   = 0;
    logic [11:0] pix_sb[$];
    logic [12:0] q_sb[$];
    logic [15:0] model_addr;

    bg_rom_sched dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .de(de),
        .draw_x(draw_x), .draw_y(draw_y), .rom_addr(rom_addr), .rom_color(rom_color),
        .pix_color(pix_color), .pix_valid(pix_valid), .q_req(q_req), .q_x(q_x), .q_y(q_y),
        .q_ack(q_ack), .q_color(q_color), .q_oob(q_oob), .q_busy(q_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [15:0] a);
        logic [31:0] t;
        t = {16'd0, a} * 32'd37 + 32'd5;
        return t[11:0] ^ {a[15:12], a[15:8]};
    endfunction

    always_comb rom_color = rom_fn(rom_addr);

    function automatic logic in_win(input int x, input int y);
        return (x >= 144) && (x <= 495) && (y >= 152) && (y <= 327);
    endfunction

    function automatic logic [15:0] win_addr(input int x, input int y);
        int v;
        v = (y - 152) * 352 + (x - 144);
        return v[15:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input logic d);
        pix_en = 1'b1;
        de     = d;
        draw_x = 10'(x);
        draw_y = 10'(y);
        if (d) pix_sb.push_back(in_win(x, y) ? rom_fn(win_addr(x, y)) : BG);
        if (d && in_win(x, y)) model_addr = win_addr(x, y);
    endtask

    task automatic test_reset;
        logic seen_ack;
        rst_n = 1'b0; pix_en = 1'b0; de = 1'b0; draw_x = '0; draw_y = '0;
        q_req = 1'b0; q_x = '0; q_y = '0;
        repeat (3) tick;
        total++; if (rom_addr !== 16'd0) begin bad++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
        total++; if (pix_color !== 12'd0 || pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix: got %0h/%0b want 0/0", pix_color, pix_valid); end
        total++; if ({q_ack, q_oob, q_busy} !== 3'b000 || q_color !== 12'd0) begin bad++; $display("FAIL reset_query: got ack/oob/busy=%b color=%0h want 000/0", {q_ack, q_oob, q_busy}, q_color); end
        rst_n = 1'b1;
        tick;
        q_x = 9'd10; q_y = 8'd2; q_req = 1'b1;
        tick;
        q_req = 1'b0;
        total++; if (q_busy !== 1'b1) begin bad++; $display("FAIL abort_accept: got busy=%0b want 1", q_busy); end
        rst_n = 1'b0;
        repeat (3) tick;
        total++; if ({q_ack, q_oob, q_busy} !== 3'b000 || q_color !== 12'd0 || rom_addr !== 16'd0) begin bad++; $display("FAIL abort_clear: got ack/oob/busy=%b color=%0h addr=%0h want 000/0/0", {q_ack, q_oob, q_busy}, q_color, rom_addr); end
        rst_n = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen_ack |= q_ack;
        end
        total++; if (seen_ack !== 1'b0 || q_busy !== 1'b0) begin bad++; $display("FAIL abort_no_ack: got ack_seen=%0b busy=%0b want 0/0", seen_ack, q_busy); end
        model_addr = 16'd0;
    endtask

    task automatic test_single_pixel(input int x, input int y);
        logic [11:0] exp_c;
        drive_pix(x, y, 1'b1);
        tick;
        pix_en = 1'b0;
        total++; if (rom_addr !== model_addr) begin bad++; $display("FAIL pix_addr(%0d,%0d): got %0d want %0d", x, y, rom_addr, model_addr); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL pix_early(%0d,%0d): got valid=%0b want 0", x, y, pix_valid); end
        tick;
        total++;
        if (pix_valid !== 1'b1 || pix_sb.size() == 0) begin
            bad++; $display("FAIL pix_latency(%0d,%0d): got valid=%0b want 1", x, y, pix_valid);
        end else begin
            exp_c = pix_sb.pop_front();
            total++; if (pix_color !== exp_c) begin bad++; $display("FAIL pix_color(%0d,%0d): got %0h want %0h", x, y, pix_color, exp_c); end
        end
        tick;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL pix_pulse(%0d,%0d): got valid=%0b want 0", x, y, pix_valid); end
    endtask

    task automatic test_query_inrange(input int qx, input int qy);
        logic [15:0] exp_a;
        logic [12:0] exp_q;
        int lat;
        exp_a = 16'(qy * 352 + qx);
        q_sb.push_back({1'b0, rom_fn(exp_a)});
        q_x = 9'(qx); q_y = 8'(qy); q_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i == 1) begin
                q_req = 1'b0;
                total++; if (q_busy !== 1'b1) begin bad++; $display("FAIL q_busy_wait: got %0b want 1", q_busy); end
            end
            if (i == 2) begin
                total++; if (rom_addr !== exp_a) begin bad++; $display("FAIL q_addr: got %0d want %0d", rom_addr, exp_a); end
            end
            if (q_ack) begin lat = i; break; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL q_latency: got %0d edges want 3", lat); end
        if (lat != 0) begin
            exp_q = q_sb.pop_front();
            total++; if ({q_oob, q_color} !== exp_q) begin bad++; $display("FAIL q_result: got oob=%0b color=%0h want oob=%0b color=%0h", q_oob, q_color, exp_q[12], exp_q[11:0]); end
        end
        model_addr = exp_a;
        tick;
        total++; if (q_ack !== 1'b0 || q_busy !== 1'b0) begin bad++; $display("FAIL q_done: got ack=%0b busy=%0b want 0/0", q_ack, q_busy); end
    endtask

    task automatic test_query_oob(input int qx, input int qy);
        logic [12:0] exp_q;
        int lat;
        q_sb.push_back({1'b1, BG});
        q_x = 9'(qx); q_y = 8'(qy); q_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            q_req = 1'b0;
            if (q_ack) begin lat = i; break; end
        end
        total++; if (lat != 1) begin bad++; $display("FAIL oob_latency(%0d,%0d): got %0d edges want 1", qx, qy, lat); end
        total++; if (rom_addr !== model_addr) begin bad++; $display("FAIL oob_addr(%0d,%0d): got %0d want %0d", qx, qy, rom_addr, model_addr); end
        if (lat != 0) begin
            exp_q = q_sb.pop_front();
            total++; if ({q_oob, q_color} !== exp_q) begin bad++; $display("FAIL oob_result(%0d,%0d): got oob=%0b color=%0h want oob=%0b color=%0h", qx, qy, q_oob, q_color, exp_q[12], exp_q[11:0]); end
        end
        tick;
        total++; if (q_ack !== 1'b0 || q_busy !== 1'b0) begin bad++; $display("FAIL oob_done: got ack=%0b busy=%0b want 0/0", q_ack, q_busy); end
    endtask

    task automatic test_starvation;
        logic [11:0] exp_c;
        logic [12:0] exp_q;
        int ack_c;
        ack_c = -1;
        q_sb.push_back({1'b0, rom_fn(16'd357)});
        q_x = 9'd5; q_y = 8'd1; q_req = 1'b1;
        for (int c = 0; c < 34; c++) begin
            if (c < 24)      drive_pix(144 + c, 160, 1'b1);
            else if (c < 30) drive_pix(0, 160, 1'b0);
            else             drive_pix(144 + c - 30, 161, 1'b1);
            tick;
            if (c == 0) q_req = 1'b0;
            if (c == 24) model_addr = 16'd357;
            total++; if (rom_addr !== model_addr) begin bad++; $display("FAIL stv_addr[%0d]: got %0d want %0d", c, rom_addr, model_addr); end
            if (c < 24) begin
                total++; if (q_busy !== 1'b1 || q_ack !== 1'b0) begin bad++; $display("FAIL stv_wait[%0d]: got busy=%0b ack=%0b want 1/0", c, q_busy, q_ack); end
            end
            if (q_ack) begin
                ack_c = c;
                exp_q = q_sb.pop_front();
                total++; if ({q_oob, q_color} !== exp_q) begin bad++; $display("FAIL stv_q_result: got oob=%0b color=%0h want oob=%0b color=%0h", q_oob, q_color, exp_q[12], exp_q[11:0]); end
            end
            if (pix_valid) begin
                exp_c = pix_sb.pop_front();
                total++; if (pix_color !== exp_c) begin bad++; $display("FAIL stv_pix[%0d]: got %0h want %0h", c, pix_color, exp_c); end
            end
        end
        pix_en = 1'b0; de = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (pix_valid) begin
                exp_c = pix_sb.pop_front();
                total++; if (pix_color !== exp_c) begin bad++; $display("FAIL stv_drain: got %0h want %0h", pix_color, exp_c); end
            end
        end
        total++; if (ack_c != 25) begin bad++; $display("FAIL stv_ack_cycle: got %0d want 25", ack_c); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single_pixel(150, 153);
        test_single_pixel(144, 152);
        test_single_pixel(495, 327);
        test_single_pixel(496, 327);
        test_query_inrange(10, 2);
        test_query_oob(352, 0);
        test_query_oob(0, 176);
        test_starvation;
        test_query_inrange(351, 175);
        total++; if (pix_sb.size() != 0 || q_sb.size() != 0) begin bad++; $display("FAIL sb_empty: got pix=%0d q=%0d want 0/0", pix_sb.size(), q_sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
